// File: rtl/updown_counter_if.sv
// Interface bundling the direction input and the count/status outputs of
// updown_counter. The master drives the direction and observes the count.
// The slave is the counter itself.
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             control;  // 0 = count up, 1 = count down
    logic [WIDTH-1:0] result;   // current registered count
    logic             wrap;     // one-cycle pulse after a wrap-around
    logic             dir;      // direction actually applied to the counter

    modport master (
        output control,
        input  result,
        input  wrap,
        input  dir
    );

    modport slave (
        input  control,
        output result,
        output wrap,
        output dir
    );
endinterface

// File: rtl/updown_counter.sv
// Free-running up/down counter. It wraps modulo 2^WIDTH and steps on every
// non-reset clock edge. Optional flop stages on the direction input allow an
// asynchronous control source. Reset is synchronous and active-high, and it
// clears the count, the wrap pulse and every synchronizer stage.
module updown_counter #(
    parameter int          WIDTH       = 4,  // 2..32
    parameter int unsigned INIT        = 0,  // reset value, < 2^WIDTH
    parameter int          SYNC_STAGES = 0   // 0..3 flop stages on control
) (
    input  logic               clk,
    input  logic               rst,
    updown_counter_if.slave    bus
);

    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic             dir_eff;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;

    if (SYNC_STAGES == 0) begin : g_no_sync
        // The integrator guarantees setup and hold, so control is used directly.
        assign dir_eff = bus.control;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // Shift control through the synchronizer chain. The oldest stage drives the counter.
        always_ff @(posedge clk) begin
            // NOTE: use non-blocking assignments for flops so that every stage samples the pre-edge value of the previous stage.
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= bus.control;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign dir_eff = sync_q[SYNC_STAGES-1];
    end

    // Step the count in the effective direction. Flag wrap from the pre-update value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= INIT_VAL;
            wrap_q  <= 1'b0;
        end else if (dir_eff) begin
            count_q <= count_q - ONE;
            wrap_q  <= (count_q == '0);
        end else begin
            count_q <= count_q + ONE;
            wrap_q  <= (count_q == MAX_VAL);
        end
    end

    assign bus.result = count_q;
    assign bus.wrap   = wrap_q;
    assign bus.dir    = dir_eff;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter. It runs two instances side by side.
// dut0 uses WIDTH=4, INIT=0 and samples control directly.
// dut1 uses WIDTH=4, INIT=5 and puts two synchronizer stages on control.
// Both instances are compared against a behavioural model on every edge.
module tb_updown_counter;

    localparam int W      = 4;
    localparam int MODV   = 1 << W;
    localparam int K[2]   = '{0, 2};
    localparam int INITV[2] = '{0, 5};

    logic clk = 1'b0;
    logic rst = 1'b0;

    updown_counter_if #(.WIDTH(W)) bus0 ();
    updown_counter_if #(.WIDTH(W)) bus1 ();

    updown_counter #(.WIDTH(W), .INIT(0), .SYNC_STAGES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    updown_counter #(.WIDTH(W), .INIT(5), .SYNC_STAGES(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: the count, the wrap flag, and for each instance
    // the history of control values still waiting to take effect.
    int m_cnt [2];
    int m_wrap[2];
    bit hist  [2][$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one edge. Advance the model, then compare both instances against it.
    task automatic step(input logic r, input logic c0, input logic c1);
        bit c[2];
        int got_res[2];
        int got_wrap[2];
        int got_dir[2];
        c[0] = c0;
        c[1] = c1;
        rst          = r;
        bus0.control = c0;
        bus1.control = c1;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_cnt[d]  = INITV[d];
                m_wrap[d] = 0;
                hist[d].delete();
                for (int j = 0; j < K[d]; j++) hist[d].push_back(1'b0);
            end else begin
                bit used;
                int nxt;
                hist[d].push_back(c[d]);
                used      = hist[d].pop_front();
                nxt       = m_cnt[d] + (used ? -1 : 1);
                m_wrap[d] = (nxt < 0 || nxt >= MODV) ? 1 : 0;
                m_cnt[d]  = (nxt + MODV) % MODV;
            end
        end
        #1;
        got_res[0]  = int'(bus0.result);
        got_res[1]  = int'(bus1.result);
        got_wrap[0] = int'(bus0.wrap);
        got_wrap[1] = int'(bus1.wrap);
        got_dir[0]  = int'(bus0.dir);
        got_dir[1]  = int'(bus1.dir);
        for (int d = 0; d < 2; d++) begin
            int exp_dir;
            exp_dir = (K[d] == 0) ? int'(c[d]) : int'(hist[d][0]);
            check($sformatf("dut%0d_result", d), got_res[d], m_cnt[d]);
            check($sformatf("dut%0d_wrap", d), got_wrap[d], m_wrap[d]);
            check($sformatf("dut%0d_dir", d), got_dir[d], exp_dir);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus0.control = 1'b0;
        bus1.control = 1'b0;
        #12;

        // Reset state.
        step(1'b1, 1'b0, 1'b0);
        check("rst_result0", bus0.result, 0);
        check("rst_wrap0", bus0.wrap, 0);
        check("rst_dir0", bus0.dir, 0);
        check("rst_result1", bus1.result, 5);

        // Up-count from reset. The 16th edge wraps 15 -> 0.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("up_seq", bus0.result, i % 16);
            check("up_wrap", bus0.wrap, (i == 16) ? 1 : 0);
        end

        // Count up to 9, then reverse both instances.
        repeat (9) step(1'b0, 1'b0, 1'b0);
        check("at_nine", bus0.result, 9);
        check("sync_pre", bus1.result, 14);
        step(1'b0, 1'b1, 1'b1);
        check("rev_8", bus0.result, 8);
        check("sync_n_inc", bus1.result, 15);
        check("sync_n_dir", bus1.dir, 0);
        step(1'b0, 1'b1, 1'b1);
        check("rev_7", bus0.result, 7);
        check("sync_n1_inc", bus1.result, 0);
        check("sync_n1_wrap", bus1.wrap, 1);
        check("sync_n1_dir", bus1.dir, 1);
        step(1'b0, 1'b1, 1'b1);
        check("rev_6", bus0.result, 6);
        check("rev_nowrap", bus0.wrap, 0);
        check("sync_n2_dec", bus1.result, 15);
        check("sync_n2_wrap", bus1.wrap, 1);

        // Keep counting down through 0 -> 15.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check("down_seq", bus0.result, (6 - i + 16) % 16);
            check("down_wrap", bus0.wrap, (i == 7) ? 1 : 0);
        end

        // Reach 15 counting up, then reset while a wrap would be due.
        step(1'b0, 1'b0, 1'b0);
        check("pre_rst_15", bus0.result, 15);
        step(1'b1, 1'b0, 1'b0);
        check("mid_rst_result", bus0.result, 0);
        check("mid_rst_wrap", bus0.wrap, 0);
        check("mid_rst_result1", bus1.result, 5);
        step(1'b0, 1'b0, 1'b0);
        check("resume", bus0.result, 1);

        // Random direction changes with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
